convert_real_pipe: RTL and testbench

- Registered, multi-channel fixed-point real format converter.
- Re-scales N_CH signed fixed-point values from an input exponent to an output exponent and re-sizes them from one width to another.
- Adds round-half-up on right shifts and valid/ready flow control.
- Sits between fixed-point real producers and consumers whose formats differ, where a combinational re-scale cannot meet timing.

---
 rtl/convert_real_pkg.sv | 38 +++
 rtl/convert_real_lane.sv | 123 ++++++++++++
 rtl/convert_real_pipe.sv | 80 ++++++++
 tb/tb_convert_real_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/convert_real_pkg.sv
`default_nettype none
// ============================================================================
// Module      : convert_real_pkg
// Description : Elaboration-time helpers for the fixed-point real converter:
//               shift amount, intermediate width, rounding constant and the
//               signed range limits of the output width.
// Revision    : 1.0 - initial release
// ============================================================================
package convert_real_pkg;

    // Positive result = left shift, negative result = right shift.
    function automatic int lshift(input int in_exp, input int out_exp);
        return in_exp - out_exp;
    endfunction

    // Width that holds the shifted value without loss, plus a guard bit so
    // overflow against the output range stays observable.
    function automatic int iw(input int in_w, input int out_w, input int ls);
        int a;
        a = in_w + ((ls > 0) ? ls : 0);
        return ((a > out_w) ? a : out_w) + 1;
    endfunction

    // Half an output LSB, added before a right shift (round half toward +inf).
    function automatic longint round_const(input int ls);
        return (ls < 0) ? (longint'(1) << (-ls - 1)) : longint'(0);
    endfunction

    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage : convert_real_pkg
`default_nettype wire

// File: rtl/convert_real_lane.sv
`default_nettype none
// ============================================================================
// Module      : convert_real_lane
// Description : One channel of the converter datapath.
//               S1 : sign-extend, shift (with rounding on right shifts).
//               S2 : narrow to OUT_WIDTH; with CONVERT_REAL_SAT_EN defined the
//                    value saturates and a sticky overflow bit is kept,
//                    otherwise the MSBs are dropped and o_ovf is 0.
// Ports       : clk, rst        - clock / async active-high reset
//               i_adv1, i_adv2  - stage load enables from shared control
//               i_s1_valid      - S1 holds a real beat (qualifies overflow)
//               i_din           - signed input mantissa
//               o_dout          - signed converted mantissa
//               o_ovf           - sticky overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module convert_real_lane
    import convert_real_pkg::*;
#(
    parameter int IN_WIDTH     = 16,
    parameter int IN_EXPONENT  = -8,
    parameter int OUT_WIDTH    = 16,
    parameter int OUT_EXPONENT = -8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_adv1,
    input  logic                 i_adv2,
    input  logic                 i_s1_valid,
    input  logic [IN_WIDTH-1:0]  i_din,
    output logic [OUT_WIDTH-1:0] o_dout,
    output logic                 o_ovf
);

    localparam int c_LSH = lshift(IN_EXPONENT, OUT_EXPONENT);
    localparam int c_IW  = iw(IN_WIDTH, OUT_WIDTH, c_LSH);
    localparam int c_RSH = (c_LSH < 0) ? -c_LSH : 0;

    logic signed [c_IW-1:0]  w_scaled;
    logic signed [c_IW-1:0]  r_s1;
    logic [OUT_WIDTH-1:0]    w_narrow;
    logic [OUT_WIDTH-1:0]    r_out;

    // ------------------------------------------------------------------
    // Shift / round
    // ------------------------------------------------------------------
    if (c_LSH >= 0) begin : g_left
        logic signed [c_IW-1:0] w_ext;
        assign w_ext    = {{(c_IW-IN_WIDTH){i_din[IN_WIDTH-1]}}, i_din};
        assign w_scaled = w_ext <<< c_LSH;
    end else begin : g_right
        // The sum is widened by the shift distance so the rounding constant
        // always fits, even when the shift exceeds the input width.
        localparam int c_AW = c_IW + c_RSH;
        localparam logic signed [c_AW-1:0] c_RC = c_AW'(round_const(c_LSH));
        logic signed [c_AW-1:0] w_ext;
        logic signed [c_AW-1:0] w_sum;
        assign w_ext    = {{(c_AW-IN_WIDTH){i_din[IN_WIDTH-1]}}, i_din};
        assign w_sum    = w_ext + c_RC;
        assign w_scaled = c_IW'(w_sum >>> c_RSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
        end else if (i_adv1) begin
            r_s1 <= w_scaled;
        end
    end

    // ------------------------------------------------------------------
    // Narrow
    // ------------------------------------------------------------------
`ifdef CONVERT_REAL_SAT_EN
    localparam logic signed [c_IW-1:0] c_MAX_IW = c_IW'(sat_max(OUT_WIDTH));
    localparam logic signed [c_IW-1:0] c_MIN_IW = c_IW'(sat_min(OUT_WIDTH));

    logic w_hi;
    logic w_lo;
    logic r_ovf;

    assign w_hi = (r_s1 > c_MAX_IW);
    assign w_lo = (r_s1 < c_MIN_IW);

    always_comb begin
        w_narrow = OUT_WIDTH'(r_s1);
        if (w_hi) begin
            w_narrow = OUT_WIDTH'(c_MAX_IW);
        end else if (w_lo) begin
            w_narrow = OUT_WIDTH'(c_MIN_IW);
        end
    end

    // Only a real beat may raise the flag; bubbles also flow through S1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (i_adv2 && i_s1_valid && (w_hi || w_lo)) begin
            r_ovf <= 1'b1;
        end
    end

    assign o_ovf = r_ovf;
`else
    logic w_unused_s1_valid;

    assign w_narrow          = OUT_WIDTH'(r_s1);
    assign o_ovf             = 1'b0;
    assign w_unused_s1_valid = i_s1_valid;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else if (i_adv2) begin
            r_out <= w_narrow;
        end
    end

    assign o_dout = r_out;

endmodule : convert_real_lane
`default_nettype wire

// File: rtl/convert_real_pipe.sv
`default_nettype none
// ============================================================================
// Module      : convert_real_pipe
// Description : Two-stage registered multi-channel fixed-point re-scaler.
//               Converts N_CH signed mantissas from IN_WIDTH / IN_EXPONENT to
//               OUT_WIDTH / OUT_EXPONENT with round-half-up on right shifts.
//               Optional macro CONVERT_REAL_SAT_EN enables output saturation
//               and the sticky per-channel ovf flags.
// Ports       : clk, rst   - clock / async active-high reset
//               in_valid, in_ready, in   - input beat (channel 0 in LSBs)
//               out_valid, out_ready, out - output beat (channel 0 in LSBs)
//               ovf        - sticky per-channel overflow
// Revision    : 1.0 - initial release
// ============================================================================
module convert_real_pipe
    import convert_real_pkg::*;
#(
    parameter int N_CH         = 1,
    parameter int IN_WIDTH     = 16,
    parameter int IN_EXPONENT  = -8,
    parameter int OUT_WIDTH    = 16,
    parameter int OUT_EXPONENT = -8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_CH*IN_WIDTH-1:0]  in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_CH*OUT_WIDTH-1:0] out,
    output logic [N_CH-1:0]           ovf
);

    logic r_s1_valid;
    logic r_s2_valid;
    logic w_adv1;
    logic w_adv2;

    // A stage may load when it is empty or its successor is moving; this
    // lets a full pipeline advance every cycle without a bubble.
    assign w_adv2    = !r_s2_valid || out_ready;
    assign w_adv1    = !r_s1_valid || w_adv2;
    assign in_ready  = w_adv1;
    assign out_valid = r_s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= in_valid;
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        convert_real_lane #(
            .IN_WIDTH     (IN_WIDTH),
            .IN_EXPONENT  (IN_EXPONENT),
            .OUT_WIDTH    (OUT_WIDTH),
            .OUT_EXPONENT (OUT_EXPONENT)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .i_adv1     (w_adv1),
            .i_adv2     (w_adv2),
            .i_s1_valid (r_s1_valid),
            .i_din      (in[g*IN_WIDTH +: IN_WIDTH]),
            .o_dout     (out[g*OUT_WIDTH +: OUT_WIDTH]),
            .o_ovf      (ovf[g])
        );
    end

endmodule : convert_real_pipe
`default_nettype wire

// File: tb/tb_convert_real_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_convert_real_pipe
// Description : Self-checking bench. Three converter instances share one
//               valid/ready stream:
//                 r : 2 ch, 16/-8 -> 16/-4 (right shift 4, rounding)
//                 l : 1 ch, 16/-4 -> 12/-8 (left shift 4, narrowing)
//                 i : 2 ch, 16/-8 -> 16/-8 (identity)
//               Honours CONVERT_REAL_SAT_EN for expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_convert_real_pipe;

`ifdef CONVERT_REAL_SAT_EN
    localparam bit c_SAT = 1'b1;
`else
    localparam bit c_SAT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_r;
    logic [15:0] in_l;
    logic [31:0] in_i;
    logic        in_ready_r, in_ready_l, in_ready_i;
    logic        out_valid_r, out_valid_l, out_valid_i;
    logic [31:0] out_r;
    logic [11:0] out_l;
    logic [31:0] out_i;
    logic [1:0]  ovf_r;
    logic [0:0]  ovf_l;
    logic [1:0]  ovf_i;

    convert_real_pipe #(.N_CH(2), .IN_WIDTH(16), .IN_EXPONENT(-8),
                        .OUT_WIDTH(16), .OUT_EXPONENT(-4)) dut_r (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .in(in_r),
        .out_valid(out_valid_r), .out_ready(out_ready), .out(out_r), .ovf(ovf_r));

    convert_real_pipe #(.N_CH(1), .IN_WIDTH(16), .IN_EXPONENT(-4),
                        .OUT_WIDTH(12), .OUT_EXPONENT(-8)) dut_l (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .in(in_l),
        .out_valid(out_valid_l), .out_ready(out_ready), .out(out_l), .ovf(ovf_l));

    convert_real_pipe #(.N_CH(2), .IN_WIDTH(16), .IN_EXPONENT(-8),
                        .OUT_WIDTH(16), .OUT_EXPONENT(-8)) dut_i (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_i), .in(in_i),
        .out_valid(out_valid_i), .out_ready(out_ready), .out(out_i), .ovf(ovf_i));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: real-valued rescale, then saturate or wrap.
    // ------------------------------------------------------------------
    function automatic int sx16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic void conv(input int x, input int lsh, input int ow,
                                 output int y, output bit ov);
        longint r, mx, mn, m;
        if (lsh >= 0) r = longint'(x) * (longint'(1) << lsh);
        else          r = longint'($floor(real'(x) / (2.0 ** (-lsh)) + 0.5));
        mx = (longint'(1) << (ow - 1)) - 1;
        mn = -(longint'(1) << (ow - 1));
        ov = (r > mx) || (r < mn);
        if (c_SAT) begin
            if (r > mx) r = mx;
            else if (r < mn) r = mn;
        end
        m = longint'(1) << ow;
        r = r % m;
        if (r < 0) r = r + m;
        y = int'(r);
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard / protocol monitor (samples on the falling edge)
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] er;
        logic [1:0]  ovr;
        logic [11:0] el;
        logic        ovl;
        logic [31:0] ei;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_out = 0;
    bit          lat_chk = 1'b0;
    logic [1:0]  st_r = '0;
    logic        st_l = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] prev_r, prev_i;
    logic [11:0] prev_l;

    always @(negedge clk) begin
        exp_t e;
        int   y0, y1;
        bit   o0, o1;
        cyc++;
        if (rst) begin
            q.delete();
            st_r = '0;
            st_l = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk("in_ready_r", in_ready_r, (q.size() < 2) || out_ready);
            chk("in_ready_l", in_ready_l, (q.size() < 2) || out_ready);
            chk("in_ready_i", in_ready_i, (q.size() < 2) || out_ready);
            if (stall_prev) begin
                chk("stall_valid", out_valid_r, 1);
                chk("stall_out_r", out_r, prev_r);
                chk("stall_out_l", out_l, prev_l);
                chk("stall_out_i", out_i, prev_i);
            end
            if (q.size() == 0) begin
                chk("idle_out_valid_r", out_valid_r, 0);
                chk("idle_out_valid_l", out_valid_l, 0);
                chk("idle_out_valid_i", out_valid_i, 0);
            end else if (out_valid_r && out_ready) begin
                e = q.pop_front();
                st_r = st_r | e.ovr;
                st_l = st_l | e.ovl;
                chk("out_valid_l", out_valid_l, 1);
                chk("out_valid_i", out_valid_i, 1);
                chk("out_r", out_r, e.er);
                chk("out_l", out_l, e.el);
                chk("out_i", out_i, e.ei);
                chk("ovf_r", ovf_r, c_SAT ? st_r : 2'b00);
                chk("ovf_l", ovf_l, c_SAT ? st_l : 1'b0);
                chk("ovf_i", ovf_i, 0);
                if (lat_chk) chk("latency", cyc - e.cyc, 2);
            end
            if (out_valid_r && out_ready) n_out++;
            stall_prev = out_valid_r && !out_ready;
            prev_r = out_r;
            prev_l = out_l;
            prev_i = out_i;
            if (in_valid && in_ready_r) begin
                conv(sx16(in_r[15:0]), -4, 16, y0, o0);
                conv(sx16(in_r[31:16]), -4, 16, y1, o1);
                e.er  = {y1[15:0], y0[15:0]};
                e.ovr = {o1, o0};
                conv(sx16(in_l), 4, 12, y0, o0);
                e.el  = y0[11:0];
                e.ovl = o0;
                conv(sx16(in_i[15:0]), 0, 16, y0, o0);
                conv(sx16(in_i[31:16]), 0, 16, y1, o1);
                e.ei  = {y1[15:0], y0[15:0]};
                e.cyc = cyc;
                q.push_back(e);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed vectors
    // ------------------------------------------------------------------
    typedef struct {
        logic [15:0] a;   // dut_r channel 0 input
        logic [15:0] b;   // dut_r channel 1 input
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] l;   // dut_l input
        logic [11:0] el;
    } vec_t;

    vec_t tv[6];

    task automatic rand_data();
        in_r = $urandom;
        in_i = $urandom;
        in_l = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                           : 16'($urandom_range(0, 255) - 128);
    endtask

    initial begin
        logic [31:0] bp_r[4];
        logic [15:0] bp_l[4];
        int          idx;
        int          n0;
        bit          acc;

        tv[0] = '{16'h0128, 16'hFED8, 16'h0013, 16'hFFEE, 16'h0100, c_SAT ? 12'h7FF : 12'h000};
        tv[1] = '{16'h0008, 16'hFFF8, 16'h0001, 16'h0000, 16'hFF00, c_SAT ? 12'h800 : 12'h000};
        tv[2] = '{16'h0007, 16'hFFF7, 16'h0000, 16'hFFFF, 16'h0064, 12'h640};
        tv[3] = '{16'h7FFF, 16'h8000, 16'h0800, 16'hF800, 16'hFF80, 12'h800};
        tv[4] = '{16'h0018, 16'hFFE8, 16'h0002, 16'hFFFF, 16'h007F, 12'h7F0};
        tv[5] = '{16'h0010, 16'hFFF0, 16'h0001, 16'hFFFF, 16'h0080, c_SAT ? 12'h7FF : 12'h800};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_r = '0; in_l = '0; in_i = '0;
        step();
        chk("rst_out_valid", out_valid_r, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_l", out_l, 0);
        chk("rst_ovf_r", ovf_r, 0);
        chk("rst_ovf_l", ovf_l, 0);
        step();
        rst = 1'b0;
        step();
        chk("in_ready_after_rst", in_ready_r, 1);

        // Table: one isolated beat each, checked exactly two edges later.
        for (int k = 0; k < 6; k++) begin
            in_r = {tv[k].b, tv[k].a};
            in_l = tv[k].l;
            in_i = {tv[k].a, tv[k].b};
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            chk("tv_out_valid", out_valid_r, 1);
            chk("tv_out_r_ch0", out_r[15:0], tv[k].ea);
            chk("tv_out_r_ch1", out_r[31:16], tv[k].eb);
            chk("tv_out_l", out_l, tv[k].el);
            chk("tv_out_i", out_i, {tv[k].a, tv[k].b});
            step();
        end
        chk("tv_ovf_l_sticky", ovf_l, c_SAT ? 1'b1 : 1'b0);
        chk("tv_ovf_r_clear", ovf_r, 0);

        // Backpressure: A..D offered continuously, consumer stalls k=3..5.
        for (int k = 0; k < 4; k++) begin
            bp_r[k] = $urandom;
            bp_l[k] = 16'($urandom_range(0, 255) - 128);
        end
        idx = 0;
        n0 = n_out;
        for (int k = 0; k < 10; k++) begin
            in_valid  = (idx < 4);
            in_r      = bp_r[(idx < 4) ? idx : 0];
            in_l      = bp_l[(idx < 4) ? idx : 0];
            in_i      = bp_r[(idx < 4) ? idx : 0];
            out_ready = !(k >= 3 && k <= 5);
            #1;
            if (k >= 3 && k <= 5) chk("bp_in_ready_low", in_ready_r, 0);
            acc = in_valid && in_ready_r;
            step();
            if (acc) idx++;
        end
        chk("bp_accepted", idx, 4);
        chk("bp_outputs", n_out - n0, 4);

        // Full throughput: 64 back-to-back beats, latency exactly 2.
        lat_chk = 1'b1;
        n0 = n_out;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            rand_data();
            step();
        end
        in_valid = 1'b0;
        step(); step(); step();
        lat_chk = 1'b0;
        chk("tp_outputs", n_out - n0, 64);

        // Reset with both stages occupied.
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_data();
        step();
        rand_data();
        step();
        in_valid = 1'b0;
        step();
        chk("rs_full_valid", out_valid_r, 1);
        chk("rs_full_in_ready", in_ready_r, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rs_out_valid", out_valid_r, 0);
        chk("rs_out_r", out_r, 0);
        chk("rs_out_l", out_l, 0);
        chk("rs_out_i", out_i, 0);
        chk("rs_ovf_l", ovf_l, 0);
        chk("rs_ovf_r", ovf_r, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("rs_in_ready", in_ready_r, 1);
        for (int k = 0; k < 3; k++) begin
            chk("rs_no_stale", out_valid_r, 0);
            step();
        end

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            rand_data();
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("drain_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_convert_real_pipe
`default_nettype wire
